// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cla_adder
// Description : Add/subtract unit of 4-bit CLA groups; inter-group carry is
//               registered between pipeline stages, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int c_GPS = (WIDTH / 4) / STAGES;
  localparam int c_MSB = WIDTH - 1;

  // 4-bit full-lookahead group: returns {group carry-out, sum[3:0]}
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic c0);
    logic [3:0] p, g, c;
    logic       gg, gp;
    p    = a ^ b;
    g    = a & b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp   = &p;
    return {gg | (gp & c0), p ^ c};
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_effb;
  logic             w_cin0;

  logic [WIDTH-1:0] w_a_in [STAGES];
  logic [WIDTH-1:0] w_b_in [STAGES];
  logic [WIDTH-1:0] w_s_in [STAGES];
  logic [WIDTH-1:0] w_s_nx [STAGES];
  logic [STAGES-1:0] w_c_in, w_v_in, w_c_nx;

  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic [STAGES-1:0] r_c, r_v;

  assign w_effb   = sub ? ~y : y;
  assign w_cin0   = sub | cin;
  assign w_adv    = out_ready | ~r_v[STAGES-1];
  assign in_ready = w_adv;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int c_LO = k * c_GPS * 4;

      if (k == 0) begin : g_first
        assign w_a_in[k] = x;
        assign w_b_in[k] = w_effb;
        assign w_s_in[k] = '0;
        assign w_c_in[k] = w_cin0;
        assign w_v_in[k] = in_valid;
      end else begin : g_rest
        assign w_a_in[k] = r_a[k-1];
        assign w_b_in[k] = r_b[k-1];
        assign w_s_in[k] = r_s[k-1];
        assign w_c_in[k] = r_c[k-1];
        assign w_v_in[k] = r_v[k-1];
      end

      logic [WIDTH-1:0] w_sum;
      logic             w_cy;

      // This stage's groups ripple the carry group to group within one cycle
      always_comb begin
        w_sum = w_s_in[k];
        w_cy  = w_c_in[k];
        for (int j = 0; j < c_GPS; j++) begin
          {w_cy, w_sum[c_LO+4*j +: 4]} = cla4(w_a_in[k][c_LO+4*j +: 4],
                                              w_b_in[k][c_LO+4*j +: 4], w_cy);
        end
      end

      assign w_s_nx[k] = w_sum;
      assign w_c_nx[k] = w_cy;
    end
  endgenerate

  // Whole pipe moves in lockstep; data only loads behind a valid token
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_c <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else if (w_adv) begin
      r_v <= w_v_in;
      for (int k = 0; k < STAGES; k++) begin
        if (w_v_in[k]) begin
          r_a[k] <= w_a_in[k];
          r_b[k] <= w_b_in[k];
          r_s[k] <= w_s_nx[k];
          r_c[k] <= w_c_nx[k];
        end
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = (r_a[STAGES-1][c_MSB] == r_b[STAGES-1][c_MSB]) &&
                     (r_s[STAGES-1][c_MSB] != r_a[STAGES-1][c_MSB]);

endmodule
`default_nettype wire

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined add/subtract unit built from 4-bit carry-lookahead groups: per-bit propagate/generate, group P/G, and in-group lookahead carries.
- The carry between groups ripples across pipeline stages. Each stage resolves a fixed slice of groups and registers the partial sum, the carry and the unprocessed upper operand bits.
- Sits between operand producers and the Wallace-tree final-adder / accumulator path, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- STAGES, 2, number of pipeline register stages (= latency); must divide WIDTH/4 exactly.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and mode present on this cycle.
- in_ready  out  1  unit accepts operands this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- cin  in  1  carry in; used only when sub=0.
- sub  in  1  1: compute x - y; 0: compute x + y + cin.
- out_valid  out  1  result present on sum/cout/ovf.
- out_ready  in  1  downstream accepts the result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB (in subtract mode, 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All stage valid bits clear; out_valid=0.
  - sum=0, cout=0, ovf=0.
  - Data registers are cleared as well.
  - Operation resumes on the first clk edge after rst_n rises.
- Operand preparation (combinational, before stage 0):
  - Effective B = sub ? ~y : y.
  - Effective carry-in = sub ? 1 : cin.
- Group arithmetic, per 4-bit group g with incoming carry c:
  - p_i = a_i ^ b_i, g_i = a_i & b_i, s_i = p_i ^ c_i.
  - Internal carries use full lookahead.
  - Group carry-out = G | (P & c).
- Staging:
  - GPS = (WIDTH/4)/STAGES groups per stage.
  - Stage k (k = 0..STAGES-1) computes groups k*GPS .. k*GPS+GPS-1 using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
  - Stage k registers: the sum bits computed so far, the carry out of its last group, the remaining upper operand bits, and the sign bits x[MSB] and effective-B[MSB] needed for ovf.
  - Unused upper bits may be dropped stage by stage.
- Output flags:
  - The final stage register drives sum and cout.
  - ovf = (x[MSB] == effB[MSB]) && (sum[MSB] != x[MSB]).
- Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (visible in the cycle following edge N+STAGES-1), i.e. STAGES cycles.
- Throughput: one transaction per cycle when out_ready is held high.
- Handshake:
  - Global advance enable: adv = out_ready | ~out_valid.
  - in_ready = adv. Combinational from out_ready and out_valid only; no path from in_valid.
  - A transfer in occurs when in_valid & in_ready.
  - A transfer out occurs when out_valid & out_ready.
  - When adv=1, every stage loads from its predecessor. Stage 0 loads the new operands with valid = in_valid.
  - When adv=0, every stage holds; sum/cout/ovf/out_valid stay stable.
  - Bubbles inside the pipe are not collapsed while stalled.
- Boundary conditions:
  - Stalled with a full pipe: exactly STAGES transactions are held; in_ready=0; no data is lost or duplicated.
  - Simultaneous out transfer and in transfer in the same cycle: both occur; the pipe advances.
  - Carry crossing a stage boundary must propagate correctly; this is the critical case.
  - WIDTH=4, STAGES=1: a single registered 4-bit CLA with handshake.
  - x/y/cin/sub are don't-care when in_valid=0; they must not affect any output when not accepted.
  - Reset asserted mid-stream discards all in-flight transactions; out_valid drops asynchronously.

Test Plan (WIDTH=16, STAGES=2, out_ready=1 unless stated):
- Sequence 0x7FFF+0x0001 (cin=0), then 0xFFFF+0x0001, then 0x00FF+0x0001 (carry crosses the stage boundary) -> 2 cycles after each acceptance:
  - 0x8000 / cout 0 / ovf 1
  - 0x0000 / cout 1 / ovf 0
  - 0x0100 / cout 0 / ovf 0
- sub=1: 0x0005-0x0007 -> sum 0xFFFE, cout 0, ovf 0. sub=1: 0x8000-0x0001 with cin=0 -> sum 0x7FFF, cout 1, ovf 1 (cin ignored).
- 0x1234+0x4321 with cin=1 -> sum 0x5556, cout 0.
- Back-to-back stream of 100 random operations (both modes) -> results in order, one per cycle, matching a reference model.
- Backpressure: out_ready=0, offer 3 transactions -> only 2 accepted; in_ready=0 from the cycle after the pipe fills; outputs are stable while stalled. Raising out_ready drains both in order, then accepts the third.
- Reset: assert rst_n=0 with 2 transactions in flight -> out_valid=0 and sum=0 immediately. After release, a new 0x0001+0x0001 returns 0x0002 at latency 2, with no stale output.
